// File: rtl/seg7_disp_pkg.sv
// Shared seven-segment display constants: blank pattern, hex glyph table, anode levels.
package seg7_disp_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Common-anode drive levels.
  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;

endpackage

// File: rtl/seg7_scan_mux_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg7
  import seg7_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  // Table lookup of the glyph for this nibble.
  assign seg_c = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver.
// scan_clk is synchronised and edge-detected; each rising edge advances the
// active digit, with a short all-anodes-off gap, and the displayed value is
// captured once per frame so a digit never tears mid-scan.
// Optional build macro: LEAD_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_mux
  import seg7_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync_prev_q;
  logic                    tick_c;
  logic                    wrap_c;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        blank_q;
  logic [4*NUM_DIGITS-1:0] shadow_val_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;
  logic [3:0]              nib_c;
  logic                    dp_sel_c;
  logic [NUM_DIGITS-1:0]   an_sel_c;
  logic [6:0]              dec_seg_c;
  logic                    lz_blank_c;

  // Synchroniser chain plus edge register on the slow scan clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], scan_clk};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_c = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign wrap_c = (idx_q == LAST_IDX);

  // Digit index, inter-digit blank counter and per-frame shadow capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q        <= '0;
      blank_q      <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
    end else if (!en) begin
      // Keep the gap armed so the held digit reappears after a full blank interval.
      blank_q <= BLANK_LOAD;
    end else if (tick_c) begin
      idx_q   <= wrap_c ? '0 : idx_q + IDX_W'(1);
      blank_q <= BLANK_LOAD;
      if (wrap_c) begin
        shadow_val_q <= value;
        shadow_dp_q  <= dp_in;
      end
    end else if (blank_q != '0) begin
      blank_q <= blank_q - CNT_W'(1);
    end
  end

  // Select the active digit's nibble, decimal point and anode pattern.
  always_comb begin
    nib_c    = '0;
    dp_sel_c = 1'b0;
    an_sel_c = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_c       = shadow_val_q[4*i +: 4];
        dp_sel_c    = shadow_dp_q[i];
        an_sel_c[i] = AN_ON;
      end else begin
        an_sel_c[i] = AN_OFF;
      end
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic zero_above_c;

  // Blank a digit when it and every more significant digit are zero; digit 0 always shows.
  always_comb begin
    zero_above_c = 1'b1;
    lz_blank_c   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above_c = zero_above_c & (shadow_val_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        lz_blank_c = zero_above_c;
      end
    end
  end
`else
  assign lz_blank_c = 1'b0;
`endif

  hex_to_seg7 u_hex_to_seg7 (
    .nib   (nib_c),
    .seg_c (dec_seg_c)
  );

  // Registered display drive and frame marker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= en & tick_c & wrap_c;
      if (en && (blank_q == '0)) begin
        an  <= an_sel_c;
        seg <= lz_blank_c ? SEG_BLANK : dec_seg_c;
        dp  <= ~dp_sel_c;
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux (4 digits, 2 sync stages, 4 blank clks).
module tb_seg7_scan_mux;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_clk;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  cur_an;

  seg7_scan_mux #(
    .NUM_DIGITS   (4),
    .SYNC_STAGES  (2),
    .BLANK_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_clk    (scan_clk),
    .en          (en),
    .value       (value),
    .dp_in       (dp_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it misses.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One scan_clk rising edge: latency, blank gap, new digit, falling edge ignored.
  task automatic scan_step(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                           input logic exp_dp, input logic exp_fs);
    @(negedge clk) scan_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold"}, 32'(an), 32'(cur_an));
    check({tag, "_fs"}, 32'(frame_start), 32'(exp_fs));
    @(posedge clk); #1;
    check({tag, "_blank0"}, 32'(an), 32'hF);
    check({tag, "_fs_end"}, 32'(frame_start), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_blank3"}, 32'(an), 32'hF);
    @(posedge clk); #1;
    check({tag, "_an"}, 32'(an), 32'(exp_an));
    check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    check({tag, "_dp"}, 32'(dp), 32'(exp_dp));
    cur_an = exp_an;
    @(negedge clk) scan_clk = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_fall"}, 32'(an), 32'(exp_an));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout an=%0h exp=done", an);
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    scan_clk = 1'b0;
    en       = 1'b1;
    value    = 16'h1234;
    dp_in    = 4'b0100;

    // Held in reset while scan_clk toggles.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) scan_clk = ~scan_clk;
      repeat (2) @(posedge clk);
      #1;
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_fs", 32'(frame_start), 32'h0);
    end
    @(negedge clk) scan_clk = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_an", 32'(an), 32'hE);
    check("post_rst_seg", 32'(seg), 32'h40);
    check("post_rst_dp", 32'(dp), 32'h1);
    cur_an = 4'hE;

    // First frame still shows the zero shadow, then 1234 loads at wrap.
    scan_step("f0d1", 4'hD, 7'h40, 1'b1, 1'b0);
    scan_step("f0d2", 4'hB, 7'h40, 1'b1, 1'b0);
    scan_step("f0d3", 4'h7, 7'h40, 1'b1, 1'b0);
    scan_step("f1d0", 4'hE, 7'h19, 1'b1, 1'b1);
    scan_step("f1d1", 4'hD, 7'h30, 1'b1, 1'b0);
    scan_step("f1d2", 4'hB, 7'h24, 1'b0, 1'b0);
    value = 16'hABCD;
    scan_step("f1d3", 4'h7, 7'h79, 1'b1, 1'b0);
    scan_step("f2d0", 4'hE, 7'h21, 1'b1, 1'b1);
    scan_step("f2d1", 4'hD, 7'h46, 1'b1, 1'b0);
    scan_step("f2d2", 4'hB, 7'h03, 1'b0, 1'b0);
    scan_step("f2d3", 4'h7, 7'h08, 1'b1, 1'b0);

    // Disable across three scan periods; index must freeze on digit 3.
    @(negedge clk) en = 1'b0;
    @(posedge clk); #1;
    check("dis_an", 32'(an), 32'hF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) scan_clk = 1'b1;
      repeat (32) @(posedge clk);
      #1;
      check("dis_hold_an", 32'(an), 32'hF);
      check("dis_fs", 32'(frame_start), 32'h0);
      @(negedge clk) scan_clk = 1'b0;
      repeat (32) @(posedge clk);
    end
    @(negedge clk) en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("en_gap_an", 32'(an), 32'hF);
    @(posedge clk); #1;
    check("en_back_an", 32'(an), 32'h7);
    check("en_back_seg", 32'(seg), 32'h08);

    // Leading-zero handling: 0050 then 0000.
    value = 16'h0050;
    dp_in = 4'b0000;
    scan_step("lz0", 4'hE, 7'h40, 1'b1, 1'b1);
    scan_step("lz1", 4'hD, 7'h12, 1'b1, 1'b0);
    scan_step("lz2", 4'hB, LZ,    1'b1, 1'b0);
    scan_step("lz3", 4'h7, LZ,    1'b1, 1'b0);
    value = 16'h0000;
    scan_step("z0",  4'hE, 7'h40, 1'b1, 1'b1);
    scan_step("z1",  4'hD, LZ,    1'b1, 1'b0);

    // Asynchronous reset mid-digit takes effect before the next clk edge.
    value = 16'h9876;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dp", 32'(dp), 32'h1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("arst_rel_an", 32'(an), 32'hE);
    cur_an = 4'hE;
    scan_step("arst_d1", 4'hD, 7'h40, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
